// File: rtl/johnson_pkg.sv
// johnson_pkg: shared types and helpers for the parametrised Johnson/ring counter.
//   state_t     : state zero-extended to the widest supported counter (32 bits)
//   dir_e       : step direction (up = shift left, down = shift right)
//   seed_of     : reset/recovery state for a given width and mode
//   period_of   : sequence length (2*W for Johnson, W for ring)
//   is_legal    : true when a state belongs to the selected sequence
//   decode_idx  : sequence position of a legal state
package johnson_pkg;

    localparam int unsigned MAX_WIDTH      = 32;
    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_PERIOD = 2 * DEFAULT_WIDTH;

    typedef logic [MAX_WIDTH-1:0] state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int unsigned period_of(input int unsigned width, input bit ring);
        return ring ? width : 2 * width;
    endfunction

    function automatic state_t seed_of(input int unsigned width, input bit ring);
        state_t s;
        s = '0;
        if (ring && width > 0) s[0] = 1'b1;
        return s;
    endfunction

    function automatic int unsigned ones_of(input state_t s, input int unsigned width);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width && s[i]) c++;
        end
        return c;
    endfunction

    // Johnson states are either a run of ones anchored at bit 0 (idx 0..W)
    // or a run of ones anchored at the MSB (idx W+1..2W-1).
    function automatic logic is_legal(input state_t s, input int unsigned width, input bit ring);
        int unsigned c;
        logic        low_ok;
        logic        high_ok;
        c       = ones_of(s, width);
        low_ok  = 1'b1;
        high_ok = 1'b1;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                if (s[i] != (i < c))          low_ok  = 1'b0;
                if (s[i] != (i >= width - c)) high_ok = 1'b0;
            end
        end
        if (ring) return (c == 1);
        return low_ok || high_ok;
    endfunction

    function automatic int unsigned decode_idx(input state_t s, input int unsigned width, input bit ring);
        int unsigned c;
        int unsigned pos;
        c   = ones_of(s, width);
        pos = 0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width && s[i] && pos == 0) pos = i;
        end
        if (ring) return pos;
        if (s[0] || c == 0) return c;
        return 2 * width - c;
    endfunction

endpackage

// File: rtl/johnson_counter_param_legal_chk.sv
// johnson_legal_chk: combinational legality check and position decode.
//   state : candidate counter state
//   legal : state is a member of the selected sequence
//   idx   : sequence position of state (meaningful only when legal)
module johnson_legal_chk
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          RING  = 1'b0,
    parameter int unsigned IDXW  = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] state,
    output logic             legal,
    output logic [IDXW-1:0]  idx
);

    state_t ext;

    assign ext = state_t'(state);

    always_comb begin
        legal = is_legal(ext, WIDTH, RING);
        idx   = IDXW'(decode_idx(ext, WIDTH, RING));
    end

endmodule

// File: rtl/johnson_counter_param.sv
// johnson_counter_param: parametrised Johnson / one-hot ring sequencer.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   en, dir    : advance one step; 0 = up (shift left), 1 = down (shift right)
//   load, din  : synchronous parallel load (illegal din falls back to seed)
//   out, idx   : registered state and its registered sequence position
//   wrap       : one-cycle pulse after stepping into idx 0 (up) or PERIOD-1 (down)
//   err        : one-cycle pulse after illegal-state recovery or a rejected load
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter bit          RING  = 1'b0,
    parameter int unsigned IDXW  = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    localparam int unsigned      PERIOD   = period_of(WIDTH, RING);
    localparam logic [WIDTH-1:0] SEED     = WIDTH'(seed_of(WIDTH, RING));
    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(PERIOD - 1);

    logic             din_legal;
    logic [IDXW-1:0]  din_idx;
    logic             out_legal;
    logic [IDXW-1:0]  out_idx;
    logic [WIDTH-1:0] step_up;
    logic [WIDTH-1:0] step_dn;
    logic [IDXW-1:0]  idx_up;
    logic [IDXW-1:0]  idx_dn;

    johnson_legal_chk #(.WIDTH(WIDTH), .RING(RING), .IDXW(IDXW)) u_din_chk (
        .state (din),
        .legal (din_legal),
        .idx   (din_idx)
    );

    johnson_legal_chk #(.WIDTH(WIDTH), .RING(RING), .IDXW(IDXW)) u_out_chk (
        .state (out),
        .legal (out_legal),
        .idx   (out_idx)
    );

    // Johnson feeds back the inverted end bit; ring feeds it back unchanged.
    always_comb begin
        step_up = RING ? {out[WIDTH-2:0], out[WIDTH-1]} : {out[WIDTH-2:0], ~out[WIDTH-1]};
        step_dn = RING ? {out[0], out[WIDTH-1:1]}       : {~out[0], out[WIDTH-1:1]};
        idx_up  = (idx == IDX_LAST) ? '0 : idx + IDXW'(1);
        idx_dn  = (idx == '0) ? IDX_LAST : idx - IDXW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out  <= SEED;
            idx  <= '0;
            wrap <= 1'b0;
            err  <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (din_legal) begin
                out <= din;
                idx <= din_idx;
                err <= 1'b0;
            end else begin
                out <= SEED;
                idx <= '0;
                err <= 1'b1;
            end
        end else if (!out_legal) begin
            out  <= SEED;
            idx  <= '0;
            wrap <= 1'b0;
            err  <= 1'b1;
        end else if (en) begin
            err <= 1'b0;
            if (dir_e'(dir) == DIR_DOWN) begin
                out  <= step_dn;
                idx  <= idx_dn;
                wrap <= (idx_dn == IDX_LAST);
            end else begin
                out  <= step_up;
                idx  <= idx_up;
                wrap <= (idx_up == '0);
            end
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
        end
    end

    // The registered idx tracks out without being decoded from it.
    always_ff @(posedge clk) begin
        if (!reset && out_legal) begin
            assert (idx == out_idx);
        end
    end

endmodule

// File: tb/tb_johnson_counter_param.sv
module tb_johnson_counter_param;

    localparam int unsigned W   = 8;
    localparam int unsigned IW  = $clog2(2 * W);
    localparam int unsigned RW  = 5;
    localparam int unsigned RIW = $clog2(2 * RW);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset8, en8, dir8, load8;
    logic [W-1:0]  din8, out8;
    logic [IW-1:0] idx8;
    logic          wrap8, err8;

    logic           resetr, enr, dirr, loadr;
    logic [RW-1:0]  dinr, outr;
    logic [RIW-1:0] idxr;
    logic           wrapr, errr;

    johnson_counter_param #(.WIDTH(W), .RING(0)) dut8 (
        .clk(clk), .reset(reset8), .en(en8), .dir(dir8), .load(load8), .din(din8),
        .out(out8), .idx(idx8), .wrap(wrap8), .err(err8)
    );

    johnson_counter_param #(.WIDTH(RW), .RING(1)) dutr (
        .clk(clk), .reset(resetr), .en(enr), .dir(dirr), .load(loadr), .din(dinr),
        .out(outr), .idx(idxr), .wrap(wrapr), .err(errr)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] out;
        int unsigned idx;
        logic        wrap;
        logic        err;
        bit          cout;
        bit          cerr;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    bit mon8 = 1'b0;
    bit monr = 1'b0;

    // Johnson pattern at position k, built from run lengths rather than shifts.
    function automatic logic [31:0] jpat(input int unsigned w, input int unsigned k);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        if (k <= w) return (32'd1 << k) - 32'd1;
        return (m << (k - w)) & m;
    endfunction

    task automatic push(input logic [31:0] o, input int unsigned k, input logic w,
                        input logic er, input bit co, input bit ce, input string tag);
        exp_t x;
        x.out = o; x.idx = k; x.wrap = w; x.err = er; x.cout = co; x.cerr = ce; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic drv8(input logic r, input logic en_v, input logic d, input logic l, input logic [W-1:0] v);
        @(negedge clk);
        reset8 = r; en8 = en_v; dir8 = d; load8 = l; din8 = v;
    endtask

    task automatic drvr(input logic r, input logic en_v, input logic d, input logic l, input logic [RW-1:0] v);
        @(negedge clk);
        resetr = r; enr = en_v; dirr = d; loadr = l; dinr = v;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            drv8(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            push(32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b1, "reset8");
            @(posedge clk); #1;
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL reset8: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
                    bad++;
                    $display("FAIL %s: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                             e.tag, out8, idx8, wrap8, err8, e.out[W-1:0], e.idx, e.wrap, e.err);
                end
            end
        end
        mon8 = 1'b1;
    endtask

    task automatic test_count_up;
        for (int unsigned i = 1; i <= 20; i++) begin
            drv8(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            push(jpat(W, i % 16), i % 16, (i % 16) == 0, 1'b0, 1'b1, 1'b1, "count_up");
            @(posedge clk); #1;
            total++;
            e = sb.pop_front();
            if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
                bad++;
                $display("FAIL %s step %0d: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                         e.tag, i, out8, idx8, wrap8, err8, e.out[W-1:0], e.idx, e.wrap, e.err);
            end
        end
    endtask

    task automatic test_reverse;
        int unsigned ks[11] = '{0, 1, 2, 3, 2, 1, 0, 15, 14, 15, 0};
        bit          rs[11] = '{1, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0};
        bit          ds[11] = '{0, 0, 0, 0, 1, 1, 1, 1,  1,  0,  0};
        bit          ws[11] = '{0, 0, 0, 0, 0, 0, 0, 1,  0,  0,  1};
        for (int i = 0; i < 11; i++) begin
            drv8(rs[i], !rs[i], ds[i], 1'b0, 8'h00);
            push(jpat(W, ks[i]), ks[i], ws[i], 1'b0, 1'b1, 1'b1, "reverse");
            @(posedge clk); #1;
            total++;
            e = sb.pop_front();
            if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
                bad++;
                $display("FAIL %s step %0d: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                         e.tag, i, out8, idx8, wrap8, err8, e.out[W-1:0], e.idx, e.wrap, e.err);
            end
        end
    endtask

    task automatic test_load;
        logic [W-1:0] dv[4] = '{8'b11111100, 8'b01010101, 8'b00000000, 8'b00000111};
        logic         lv[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0]  eo[4] = '{32'hFC, 32'h00, 32'h00, 32'h07};
        int unsigned  ek[4] = '{10, 0, 0, 3};
        logic         ee[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drv8(1'b0, 1'b0, 1'b0, lv[i], dv[i]);
            push(eo[i], ek[i], 1'b0, ee[i], 1'b1, 1'b1, "load");
            @(posedge clk); #1;
            total++;
            e = sb.pop_front();
            if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
                bad++;
                $display("FAIL %s step %0d: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                         e.tag, i, out8, idx8, wrap8, err8, e.out[W-1:0], e.idx, e.wrap, e.err);
            end
        end
    endtask

    task automatic test_recovery;
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        force dut8.out = 8'b00100100;
        push(32'h0, 0, 1'b0, 1'b1, 1'b0, 1'b1, "recover_edge");
        @(posedge clk); #1;
        release dut8.out;
        total++;
        e = sb.pop_front();
        if (32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
            bad++;
            $display("FAIL %s: idx=%0d wrap=%b err=%b required idx=%0d wrap=%b err=%b",
                     e.tag, idx8, wrap8, err8, e.idx, e.wrap, e.err);
        end
        drv8(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        push(32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0, "recover_settle");
        @(posedge clk); #1;
        total++;
        e = sb.pop_front();
        if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap) begin
            bad++;
            $display("FAIL %s: out=%b idx=%0d wrap=%b required out=%b idx=%0d wrap=%b",
                     e.tag, out8, idx8, wrap8, e.out[W-1:0], e.idx, e.wrap);
        end
    endtask

    task automatic test_back_to_back;
        logic         rv[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         ev[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic         lv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] dv[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00, 8'hFC};
        int unsigned  ek[8] = '{0, 1, 1, 2, 2, 4, 4, 0};
        for (int i = 0; i < 8; i++) begin
            drv8(rv[i], ev[i], 1'b0, lv[i], dv[i]);
            push(jpat(W, ek[i]), ek[i], 1'b0, 1'b0, 1'b1, 1'b1, "back_to_back");
            @(posedge clk); #1;
            total++;
            e = sb.pop_front();
            if (32'(out8) !== e.out || 32'(idx8) !== e.idx || wrap8 !== e.wrap || err8 !== e.err) begin
                bad++;
                $display("FAIL %s step %0d: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                         e.tag, i, out8, idx8, wrap8, err8, e.out[W-1:0], e.idx, e.wrap, e.err);
            end
        end
    endtask

    task automatic test_ring;
        logic          rv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic          ev[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic          dr[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          lv[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [RW-1:0] dv[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'b00011, 5'b00100, 5'b01000};
        int unsigned   ek[10] = '{0, 1, 2, 3, 4, 0, 4, 0, 2, 0};
        logic          ew[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          ee[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drvr(rv[i], ev[i], dr[i], lv[i], dv[i]);
            push(32'd1 << ek[i], ek[i], ew[i], ee[i], 1'b1, 1'b1, "ring");
            @(posedge clk); #1;
            monr = 1'b1;
            total++;
            e = sb.pop_front();
            if (32'(outr) !== e.out || 32'(idxr) !== e.idx || wrapr !== e.wrap || errr !== e.err) begin
                bad++;
                $display("FAIL %s step %0d: out=%b idx=%0d wrap=%b err=%b required out=%b idx=%0d wrap=%b err=%b",
                         e.tag, i, outr, idxr, wrapr, errr, e.out[RW-1:0], e.idx, e.wrap, e.err);
            end
        end
    endtask

    // idx must equal the position of out in the sequence on every cycle.
    bit          found8, foundr;
    int unsigned k8, kr;
    always @(negedge clk) begin
        if (mon8) begin
            found8 = 1'b0;
            k8 = 0;
            for (int unsigned k = 0; k < 2 * W; k++) begin
                if (jpat(W, k) == 32'(out8)) begin found8 = 1'b1; k8 = k; end
            end
            if (found8) begin
                total++;
                if (32'(idx8) !== k8) begin
                    bad++;
                    $display("FAIL invariant8: idx=%0d required %0d for out=%b", idx8, k8, out8);
                end
            end
        end
        if (monr) begin
            foundr = 1'b0;
            kr = 0;
            for (int unsigned k = 0; k < RW; k++) begin
                if ((32'd1 << k) == 32'(outr)) begin foundr = 1'b1; kr = k; end
            end
            if (foundr) begin
                total++;
                if (32'(idxr) !== kr) begin
                    bad++;
                    $display("FAIL invariantr: idx=%0d required %0d for out=%b", idxr, kr, outr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset8 = 1'b1; en8 = 1'b0; dir8 = 1'b0; load8 = 1'b0; din8 = '0;
        resetr = 1'b1; enr = 1'b0; dirr = 1'b0; loadr = 1'b0; dinr = '0;
        test_reset;
        test_count_up;
        test_reverse;
        test_load;
        test_recovery;
        test_back_to_back;
        test_ring;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised successor to the fixed 8-bit Johnson counter. Supports configurable width, twisted-ring (Johnson) or plain ring mode, run-time direction, count enable and synchronous parallel load. Adds illegal-state detection with self-correction, a registered state index, and a wrap pulse. Used as a sequencer and phase generator in datapath control and display-scan logic.

Parameters:
WIDTH, 8, register width in bits; legal range 2 to 32.
RING, 0, 0 = Johnson (period 2*WIDTH); 1 = one-hot ring (period WIDTH).
IDXW, $clog2(2*WIDTH), width of the idx output (derived; do not override).

Ports:
clk      input   1      rising-edge clock
reset    input   1      synchronous, active-high reset
en       input   1      advance one step when high
dir      input   1      0 = up (shift left), 1 = down (shift right)
load     input   1      synchronous parallel load
din      input   WIDTH  load value
out      output  WIDTH  counter state (registered)
idx      output  IDXW   position in sequence, 0..PERIOD-1 (registered)
wrap     output  1      one-cycle pulse on sequence wrap (registered)
err      output  1      one-cycle pulse on illegal-state correction or rejected load (registered)

Behaviour:
- Seed state: Johnson is all-zeros; ring is 0…01. PERIOD is 2*WIDTH for Johnson and WIDTH for ring.
- Reset (highest priority): out=seed, idx=0, wrap=0, err=0.
- Johnson up step: out <= {out[W-2:0], ~out[W-1]}.
  - Sequence with W=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, back to 0000.
- Johnson down step: out <= {~out[0], out[W-1:1]}. This is the exact reverse sequence.
- Ring up step: rotate left. Ring down step: rotate right.
- Legal Johnson state:
  - idx k ≤ W: the low k bits are 1 and the rest are 0.
  - idx k > W: the high 2W−k bits are 1 and the rest are 0.
- Legal ring state: exactly one bit set; idx is the bit position.
- Priority per edge: reset > load > illegal-recovery > en step > hold.
- load=1, din legal: out=din, idx=decode(din), err=0, wrap=0. en is ignored that cycle.
- load=1, din illegal: out=seed, idx=0, err=1 for one cycle.
- Illegal-state recovery: if out is illegal at a clock edge with no reset or load, then out=seed, idx=0, err=1. This is checked every cycle, independent of en. Reachable only by SEU or forced state in sim.
- en=1 step: out and idx update on the same edge. idx moves to (idx+1) mod PERIOD for up, or (idx−1) mod PERIOD for down.
- wrap=1 for exactly the cycle after a step into idx 0 (up) or into idx PERIOD−1 (down). It is 0 on load, reset and recovery.
- en=0: out and idx hold; wrap=0, err=0.
- A dir change takes effect on the next enabled step with no bubble. A mid-sequence reversal retraces the previous state.
- Reset asserted mid-sequence overrides load and en in that cycle.
- idx is never derived combinationally from out. It is registered and must always equal decode(out); the bench checks this invariant every cycle.

Decomposition:
- Package johnson_pkg holds:
  - Function seed_of(WIDTH, RING).
  - Function is_legal(state, RING).
  - Function decode_idx(state, RING).
  - Localparam for PERIOD.
- One combinational sub-module, johnson_legal_chk (state in; legal and idx out), instantiated twice: on din and on out.

Test Plan:
1. W=8, RING=0: reset held for 2 cycles, then en=1, dir=0 for 20 cycles. Expect out 00000000, 00000001, …, 11111111, 11111110, …, 10000000, 00000000. Expect idx 0..15 then 0, and a single wrap pulse on the cycle idx returns to 0.
2. W=8, RING=0: from idx 3 (00000111), set dir=1. Expect 00000011, 00000001, 00000000, then 10000000 with idx=15 and wrap=1.
3. W=8, RING=0: load din=11111100 (legal). Expect out=11111100, idx=10, err=0. Then load din=01010101 (illegal). Expect out=00000000, idx=0, err=1 for one cycle.
4. W=8, RING=0: force out=00100100 in sim, with en=0. Next edge expects out=00000000, idx=0, err=1.
5. W=8, RING=0: en toggled 1,0,1,0 from reset. Expect out 00000001 held for 2 cycles, then 00000011. Simultaneous load=1 and en=1 with din=00001111 expects out=00001111, idx=4, with no extra step.
6. W=5, RING=1: reset gives 00001. With en=1 and 5 steps, expect out 00010, 00100, 01000, 10000, 00001, idx 0..4 then 0, wrap once. Reset asserted together with load=1 expects out=00001, idx=0.
